// File: rtl/dma_burst_engine_if.sv
// Wired-OR system bus bundle between a burst DMA engine (master) and the bus fabric (slave).
// Every master-driven signal must be 0 whenever that master is not the bus owner.
interface dma_burst_engine_if;
   logic        requestTransaction;
   logic        beginTransactionOut;
   logic        endTransactionOut;
   logic        dataValidOut;
   logic        readNotWriteOut;
   logic [31:0] addressDataOut;
   logic [7:0]  burstSizeOut;
   logic        transactionGranted;
   logic        dataValidIn;
   logic        endTransactionIn;
   logic        busErrorIn;
   logic        busyIn;
   logic [31:0] addressDataIn;

   modport master (
      output requestTransaction, beginTransactionOut, endTransactionOut, dataValidOut,
             readNotWriteOut, addressDataOut, burstSizeOut,
      input  transactionGranted, dataValidIn, endTransactionIn, busErrorIn, busyIn,
             addressDataIn
   );

   modport slave (
      input  requestTransaction, beginTransactionOut, endTransactionOut, dataValidOut,
             readNotWriteOut, addressDataOut, burstSizeOut,
      output transactionGranted, dataValidIn, endTransactionIn, busErrorIn, busyIn,
             addressDataIn
   );
endinterface

// File: rtl/dma_burst_engine.sv
// Burst DMA engine moving blocks between a local port-B RAM and a wired-OR system bus.
// Optional: define DMA_BUS_ERROR_EN to abort transfers on busErrorIn and report status[1].
module dma_burst_engine #(
   parameter int MEM_AW = 9
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              readNotWrite,
   input  logic [31:0]       busStartAddress,
   input  logic [MEM_AW-1:0] memStartAddress,
   input  logic [9:0]        blockSize,
   input  logic [7:0]        burstSize,
   output logic [1:0]        status,
   output logic              done,
   output logic [MEM_AW-1:0] memAddress,
   output logic              memWriteEnable,
   output logic [31:0]       memDataOut,
   input  logic [31:0]       memDataIn,
   dma_burst_engine_if.master bus
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] REQUEST   = 3'd1;
   localparam logic [2:0] INIT      = 3'd2;
   localparam logic [2:0] READ      = 3'd3;
   localparam logic [2:0] WRITE     = 3'd4;
   localparam logic [2:0] END_WRITE = 3'd5;
   localparam logic [2:0] NEXT      = 3'd6;

   logic [2:0]        state_reg;
   logic              dir_reg;
   logic [31:0]       bus_addr_reg;
   logic [MEM_AW-1:0] mem_addr_reg;
   logic [9:0]        remaining_reg;
   logic [7:0]        burst_reg;
   logic [9:0]        beats_reg;
   logic [9:0]        beat_cnt_reg;
   logic              busy_reg;
   logic              error_reg;
   logic              done_reg;

   logic [9:0] burst_beats;
   logic [9:0] beats_calc;
   logic       write_accept;
   logic       bus_err;

   assign burst_beats  = {2'b00, burst_reg} + 10'd1;
   assign beats_calc   = (burst_beats < remaining_reg) ? burst_beats : remaining_reg;
   assign write_accept = (state_reg == WRITE) && !bus.busyIn;

`ifdef DMA_BUS_ERROR_EN
   assign bus_err = bus.busErrorIn &&
                    ((state_reg == INIT) || (state_reg == READ) || (state_reg == WRITE));
`else
   logic bus_error_unused;
   assign bus_error_unused = bus.busErrorIn;
   assign bus_err = 1'b0;
`endif

   always_comb begin
      bus.requestTransaction  = 1'b0;
      bus.beginTransactionOut = 1'b0;
      bus.endTransactionOut   = 1'b0;
      bus.dataValidOut        = 1'b0;
      bus.readNotWriteOut     = 1'b0;
      bus.addressDataOut      = 32'd0;
      bus.burstSizeOut        = 8'd0;
      case (state_reg)
         REQUEST: bus.requestTransaction = 1'b1;
         INIT: begin
            bus.beginTransactionOut = 1'b1;
            bus.addressDataOut      = bus_addr_reg;
            bus.readNotWriteOut     = dir_reg;
            bus.burstSizeOut        = 8'(beats_reg - 10'd1);
         end
         WRITE: begin
            bus.dataValidOut   = 1'b1;
            bus.addressDataOut = memDataIn;
         end
         END_WRITE: bus.endTransactionOut = 1'b1;
         default: ;
      endcase
   end

   // Prefetch: on an accepted beat the next word is addressed so it arrives with no bubble;
   // while stalled the same address is re-presented, keeping the bus data stable.
   assign memAddress     = write_accept ? mem_addr_reg + MEM_AW'(1) : mem_addr_reg;
   assign memWriteEnable = (state_reg == READ) && bus.dataValidIn && !bus_err;
   assign memDataOut     = (state_reg == READ) ? bus.addressDataIn : 32'd0;
   assign status         = {error_reg, busy_reg};
   assign done           = done_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         dir_reg       <= 1'b0;
         bus_addr_reg  <= 32'd0;
         mem_addr_reg  <= '0;
         remaining_reg <= 10'd0;
         burst_reg     <= 8'd0;
         beats_reg     <= 10'd0;
         beat_cnt_reg  <= 10'd0;
         busy_reg      <= 1'b0;
         error_reg     <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  error_reg <= 1'b0;
                  if (blockSize == 10'd0) begin
                     done_reg <= 1'b1;
                  end else begin
                     dir_reg       <= readNotWrite;
                     bus_addr_reg  <= busStartAddress;
                     mem_addr_reg  <= memStartAddress;
                     remaining_reg <= blockSize;
                     burst_reg     <= burstSize;
                     busy_reg      <= 1'b1;
                     state_reg     <= REQUEST;
                  end
               end
            end
            REQUEST: begin
               if (bus.transactionGranted) begin
                  beats_reg <= beats_calc;
                  state_reg <= INIT;
               end
            end
            INIT: begin
               beat_cnt_reg <= 10'd0;
               state_reg    <= dir_reg ? READ : WRITE;
            end
            READ: begin
               if (bus.dataValidIn) mem_addr_reg <= mem_addr_reg + MEM_AW'(1);
               if (bus.endTransactionIn) state_reg <= NEXT;
            end
            WRITE: begin
               if (write_accept) begin
                  mem_addr_reg <= mem_addr_reg + MEM_AW'(1);
                  beat_cnt_reg <= beat_cnt_reg + 10'd1;
                  if (beat_cnt_reg == beats_reg - 10'd1) state_reg <= END_WRITE;
               end
            end
            END_WRITE: state_reg <= NEXT;
            NEXT: begin
               bus_addr_reg  <= bus_addr_reg + {20'd0, beats_reg, 2'b00};
               remaining_reg <= remaining_reg - beats_reg;
               if (remaining_reg != beats_reg) begin
                  state_reg <= REQUEST;
               end else begin
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
         if (bus_err) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            error_reg <= 1'b1;
            done_reg  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed bench for dma_burst_engine: table of transfers plus hand-written corner sequences.
// Honours DMA_BUS_ERROR_EN to select the expected bus-error behaviour.
module tb_dma_burst_engine;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        readNotWrite;
   logic [31:0] busStartAddress;
   logic [8:0]  memStartAddress;
   logic [9:0]  blockSize;
   logic [7:0]  burstSize;
   logic [1:0]  status;
   logic        done;
   logic [8:0]  memAddress;
   logic        memWriteEnable;
   logic [31:0] memDataOut;
   logic [31:0] memDataIn;

   dma_burst_engine_if bus();

   dma_burst_engine #(.MEM_AW(9)) dut (
      .clock(clock), .reset(reset), .start(start), .readNotWrite(readNotWrite),
      .busStartAddress(busStartAddress), .memStartAddress(memStartAddress),
      .blockSize(blockSize), .burstSize(burstSize), .status(status), .done(done),
      .memAddress(memAddress), .memWriteEnable(memWriteEnable), .memDataOut(memDataOut),
      .memDataIn(memDataIn), .bus(bus)
   );

   always #5 clock = ~clock;

   // Local port-B RAM with one-cycle registered read, plus a preload port for the bench.
   logic [31:0] mem [0:511];
   logic        pre_we;
   logic [8:0]  pre_addr;
   logic [31:0] pre_data;
   always @(posedge clock) begin
      if (memWriteEnable) mem[memAddress] <= memDataOut;
      else if (pre_we) mem[pre_addr] <= pre_data;
      memDataIn <= mem[memAddress];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return a ^ 32'h5A5A0000;
   endfunction

   function automatic logic [31:0] wr_word(input int idx, input int i);
      return 32'hC0DE0000 + 32'(idx << 8) + 32'(i);
   endfunction

   function automatic logic [31:0] idle_bits();
      return {22'd0, bus.requestTransaction, bus.beginTransactionOut, bus.endTransactionOut,
              bus.dataValidOut, bus.readNotWriteOut, |bus.addressDataOut, |bus.burstSizeOut,
              memWriteEnable, |memDataOut, done};
   endfunction

   typedef struct {
      logic        rnw;
      logic [31:0] bus_addr;
      logic [8:0]  mem_addr;
      logic [9:0]  blk;
      logic [7:0]  bsz;
      logic [15:0] stall;
      int          poke;
      int          exp_bursts;
      logic [31:0] exp_last_addr;
      logic [7:0]  exp_last_bsz;
   } vec_t;

   vec_t vecs [6];

   task automatic clear_bus_inputs();
      bus.transactionGranted = 1'b0;
      bus.dataValidIn        = 1'b0;
      bus.endTransactionIn   = 1'b0;
      bus.busErrorIn         = 1'b0;
      bus.busyIn             = 1'b0;
      bus.addressDataIn      = 32'd0;
   endtask

   task automatic run_xfer(input int idx);
      vec_t v;
      int beat, burst_left, bursts, dones, ends, bad_we, cyc;
      logic in_read, in_write, stalled, seen_done, drove;
      logic [31:0] last_addr;
      logic [7:0]  last_bsz;
      v = vecs[idx];
      beat = 0; burst_left = 0; bursts = 0; dones = 0; ends = 0; bad_we = 0; cyc = 0;
      in_read = 1'b0; in_write = 1'b0; stalled = 1'b0; seen_done = 1'b0;
      last_addr = 32'd0; last_bsz = 8'd0;
      if (!v.rnw) begin
         for (int i = 0; i < int'(v.blk); i++) begin
            @(negedge clock);
            pre_we = 1'b1; pre_addr = 9'(v.mem_addr + 9'(i)); pre_data = wr_word(idx, i);
         end
         @(negedge clock);
         pre_we = 1'b0;
      end
      @(negedge clock);
      readNotWrite = v.rnw; busStartAddress = v.bus_addr; memStartAddress = v.mem_addr;
      blockSize = v.blk; burstSize = v.bsz; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      while (!seen_done && cyc < 600) begin
         clear_bus_inputs();
         start = 1'b0;
         drove = 1'b0;
         if (cyc == v.poke) begin
            start = 1'b1; blockSize = 10'd0; busStartAddress = 32'hDEAD0000;
         end
         if (bus.requestTransaction) bus.transactionGranted = 1'b1;
         if (bus.beginTransactionOut) begin
            bursts++;
            if (bursts == 1) chk("first_addr", bus.addressDataOut, v.bus_addr);
            chk("rnw_out", 32'(bus.readNotWriteOut), 32'(v.rnw));
            last_addr = bus.addressDataOut;
            last_bsz = bus.burstSizeOut;
            burst_left = int'(bus.burstSizeOut) + 1;
            in_read = v.rnw;
            in_write = !v.rnw;
         end else if (in_read && burst_left > 0) begin
            bus.dataValidIn = 1'b1;
            bus.addressDataIn = rd_word(v.bus_addr + 32'(4 * beat));
            bus.endTransactionIn = (burst_left == 1);
            drove = 1'b1;
         end else if (in_write && bus.dataValidOut) begin
            chk("wr_data", bus.addressDataOut, wr_word(idx, beat));
            if (v.stall[beat] && !stalled) begin
               bus.busyIn = 1'b1;
               stalled = 1'b1;
            end else begin
               stalled = 1'b0;
               beat++;
               burst_left--;
               if (burst_left == 0) in_write = 1'b0;
            end
         end
         #1;
         if (drove) begin
            chk("rd_we", 32'(memWriteEnable), 32'd1);
            chk("rd_maddr", 32'(memAddress), 32'(9'(v.mem_addr + 9'(beat))));
            chk("rd_mdata", memDataOut, bus.addressDataIn);
            beat++;
            burst_left--;
            if (burst_left == 0) in_read = 1'b0;
         end else if (memWriteEnable) begin
            bad_we++;
         end
         if (bus.endTransactionOut) ends++;
         if (done) begin
            dones++;
            seen_done = 1'b1;
         end
         @(negedge clock);
         cyc++;
      end
      clear_bus_inputs();
      for (int t = 0; t < 3; t++) begin
         #1;
         if (done) dones++;
         if (memWriteEnable) bad_we++;
         @(negedge clock);
      end
      #1;
      chk("xfer_timeout", 32'(seen_done), 32'd1);
      chk("bursts", 32'(bursts), 32'(v.exp_bursts));
      chk("last_addr", last_addr, v.exp_last_addr);
      chk("last_bsz", 32'(last_bsz), 32'(v.exp_last_bsz));
      chk("beats", 32'(beat), 32'(v.blk));
      chk("done_count", 32'(dones), 32'd1);
      chk("end_count", 32'(ends), v.rnw ? 32'd0 : 32'(bursts));
      chk("stray_we", 32'(bad_we), 32'd0);
      chk("status_after", 32'(status), 32'd0);
      chk("idle_outputs", idle_bits(), 32'd0);
      if (v.rnw) begin
         for (int i = 0; i < int'(v.blk); i++)
            chk("mem_word", mem[9'(v.mem_addr + 9'(i))], rd_word(v.bus_addr + 32'(4 * i)));
      end
      $display("xfer %0d rnw=%0d bus=0x%0h mem=%0d blk=%0d bsz=%0d bursts=%0d dones=%0d ends=%0d",
               idx, v.rnw, v.bus_addr, v.mem_addr, v.blk, v.bsz, bursts, dones, ends);
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h00001000, 9'd0,   10'd8, 8'd3, 16'h0000, 4,  2, 32'h00001010, 8'd3};
      vecs[1] = '{1'b1, 32'h00002000, 9'd510, 10'd4, 8'd3, 16'h0000, -1, 1, 32'h00002000, 8'd3};
      vecs[2] = '{1'b0, 32'h00003000, 9'd16,  10'd5, 8'd3, 16'h000A, -1, 2, 32'h00003010, 8'd0};
      vecs[3] = '{1'b1, 32'hFFFFFFF8, 9'd100, 10'd3, 8'd7, 16'h0000, -1, 1, 32'hFFFFFFF8, 8'd2};
      vecs[4] = '{1'b1, 32'hFFFFFFF8, 9'd200, 10'd5, 8'd1, 16'h0000, -1, 3, 32'h00000008, 8'd0};
      vecs[5] = '{1'b0, 32'h00000040, 9'd300, 10'd3, 8'd0, 16'h0007, -1, 3, 32'h00000048, 8'd0};

      reset = 1'b1; start = 1'b0; readNotWrite = 1'b0; busStartAddress = 32'd0;
      memStartAddress = 9'd0; blockSize = 10'd0; burstSize = 8'd0;
      pre_we = 1'b0; pre_addr = 9'd0; pre_data = 32'd0;
      clear_bus_inputs();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("reset_outputs", idle_bits(), 32'd0);
      chk("reset_status", 32'(status), 32'd0);
      chk("reset_maddr", 32'(memAddress), 32'd0);
      $display("reset released status=%0d done=%0d", status, done);

      for (int i = 0; i < 6; i++) run_xfer(i);

      // Zero-length start: done next cycle, bus untouched.
      @(negedge clock);
      blockSize = 10'd0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      #1;
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_status", 32'(status), 32'd0);
      begin
         int req_seen, extra_done;
         req_seen = 0; extra_done = 0;
         for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            #1;
            if (bus.requestTransaction) req_seen++;
            if (done) extra_done++;
         end
         chk("zero_no_request", 32'(req_seen), 32'd0);
         chk("zero_single_done", 32'(extra_done), 32'd0);
      end
      $display("zero-length start done");

      // Reset during the second beat of a write burst.
      @(negedge clock);
      readNotWrite = 1'b0; busStartAddress = 32'h00005000; memStartAddress = 9'd40;
      blockSize = 10'd4; burstSize = 8'd3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("rst_req", 32'(bus.requestTransaction), 32'd1);
      bus.transactionGranted = 1'b1;
      @(negedge clock);
      bus.transactionGranted = 1'b0;
      chk("rst_init", 32'(bus.beginTransactionOut), 32'd1);
      @(negedge clock);
      chk("rst_beat0", 32'(bus.dataValidOut), 32'd1);
      @(negedge clock);
      chk("rst_beat1", 32'(bus.dataValidOut), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_outputs", idle_bits(), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_maddr", 32'(memAddress), 32'd0);
      begin
         int activity;
         activity = 0;
         for (int t = 0; t < 5; t++) begin
            @(negedge clock);
            #1;
            if (done || bus.endTransactionOut || bus.requestTransaction) activity++;
         end
         chk("rst_quiet", 32'(activity), 32'd0);
      end
      $display("reset mid-write aborted");
      run_xfer(1);

      // Bus error on the second read beat.
      @(negedge clock);
      readNotWrite = 1'b1; busStartAddress = 32'h00006000; memStartAddress = 9'd60;
      blockSize = 10'd4; burstSize = 8'd3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      bus.transactionGranted = 1'b1;
      @(negedge clock);
      bus.transactionGranted = 1'b0;
      chk("err_init", 32'(bus.beginTransactionOut), 32'd1);
      @(negedge clock);
      bus.dataValidIn = 1'b1; bus.addressDataIn = 32'h11111111;
      #1;
      chk("err_beat0_we", 32'(memWriteEnable), 32'd1);
      @(negedge clock);
      bus.busErrorIn = 1'b1; bus.addressDataIn = 32'h22222222;
      #1;
`ifdef DMA_BUS_ERROR_EN
      chk("err_beat1_we", 32'(memWriteEnable), 32'd0);
      @(negedge clock);
      bus.busErrorIn = 1'b0; bus.addressDataIn = 32'h33333333;
      #1;
      chk("err_status", 32'(status), 32'd2);
      chk("err_done", 32'(done), 32'd1);
      begin
         int wes, dn;
         wes = 0; dn = 0;
         for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            bus.endTransactionIn = (t == 3);
            #1;
            if (memWriteEnable) wes++;
            if (done) dn++;
         end
         clear_bus_inputs();
         chk("err_no_we", 32'(wes), 32'd0);
         chk("err_single_done", 32'(dn), 32'd0);
         chk("err_status_hold", 32'(status), 32'd2);
      end
`else
      chk("err_ignored_we", 32'(memWriteEnable), 32'd1);
      @(negedge clock);
      bus.busErrorIn = 1'b0; bus.addressDataIn = 32'h33333333;
      @(negedge clock);
      bus.addressDataIn = 32'h44444444; bus.endTransactionIn = 1'b1;
      begin
         int cyc, dn;
         cyc = 0; dn = 0;
         while (dn == 0 && cyc < 20) begin
            @(negedge clock);
            clear_bus_inputs();
            #1;
            if (done) dn++;
            cyc++;
         end
         chk("err_ignored_done", 32'(dn), 32'd1);
         chk("err_ignored_status", 32'(status), 32'd0);
         chk("err_ignored_mem3", mem[9'd63], 32'h44444444);
      end
`endif
      $display("bus error sequence done status=%0d", status);
      run_xfer(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
